wb_stage_writer: RTL and testbench



---
 rtl/wb_stage_writer_pkg.sv | 18 +
 rtl/wb_fwd_cmp.sv | 17 +
 rtl/wb_stage_writer.sv | 99 +++++++++
 tb/tb_wb_stage_writer.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/wb_stage_writer_pkg.sv
// Shared definitions for the MEM/WB stage: write-back source encoding,
// default widths and the hard-wired zero register address.
package wb_stage_writer_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 3;
  localparam int CNT_W  = 16;

  typedef enum logic [1:0] {
    WBSEL_ALU  = 2'd0,
    WBSEL_MEM  = 2'd1,
    WBSEL_LINK = 2'd2,
    WBSEL_IMM  = 2'd3
  } wbsel_e;

  localparam logic [2:0] REG_ZERO = 3'd0;

endpackage

// File: rtl/wb_fwd_cmp.sv
// Two-port address comparator: flags decode read ports whose address
// matches a pending register-file write.
module wb_fwd_cmp #(
  parameter int AW = 3
) (
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [AW-1:0] rs1,
  input  logic [AW-1:0] rs2,
  output logic          fwd_a,
  output logic          fwd_b
);

  assign fwd_a = wr_en && (rs1 == wr_addr);
  assign fwd_b = wr_en && (rs2 == wr_addr);

endmodule

// File: rtl/wb_stage_writer.sv
// MEM/WB pipeline register and write-side driver of the register file,
// with same-cycle forwarding flags and a retired-instruction counter.
module wb_stage_writer
  import wb_stage_writer_pkg::*;
#(
  parameter int DW = DATA_W,
  parameter int AW = ADDR_W,
  parameter int CW = CNT_W
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic          in_RegWr,
  input  logic [AW-1:0] in_Rd,
  input  logic [1:0]    in_WBsel,
  input  logic [DW-1:0] in_ALUres,
  input  logic [DW-1:0] in_MemData,
  input  logic [DW-1:0] in_PCplus,
  input  logic [DW-1:0] in_Imm,
  input  logic          stall,
  input  logic          flush,
  input  logic [AW-1:0] Rs1,
  input  logic [AW-1:0] Rs2,
  output logic          RegWr,
  output logic [AW-1:0] Rd,
  output logic [DW-1:0] WBbus,
  output logic          FwdA,
  output logic          FwdB,
  output logic [CW-1:0] retired
);

  logic          valid_q, valid_d;
  logic          wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [DW-1:0] wbbus_q, wbbus_d;
  logic [CW-1:0] retired_q, retired_d;
  logic [DW-1:0] wb_mux;
  logic          capture;

  always_comb begin
    unique case (wbsel_e'(in_WBsel))
      WBSEL_ALU:  wb_mux = in_ALUres;
      WBSEL_MEM:  wb_mux = in_MemData;
      WBSEL_LINK: wb_mux = in_PCplus;
      default:    wb_mux = in_Imm;
    endcase
  end

  assign capture = !flush && !stall;

  // NOTE: every _d gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    valid_d   = 1'b0;
    wr_d      = 1'b0;
    rd_d      = rd_q;
    wbbus_d   = wbbus_q;
    retired_d = retired_q;
    if (capture) begin
      valid_d   = in_valid;
      wr_d      = in_RegWr;
      rd_d      = in_Rd;
      wbbus_d   = wb_mux;
      retired_d = retired_q + CW'(in_valid);
    end
  end

  // NOTE: state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      wr_q      <= 1'b0;
      rd_q      <= '0;
      wbbus_q   <= '0;
      retired_q <= '0;
    end else begin
      valid_q   <= valid_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      wbbus_q   <= wbbus_d;
      retired_q <= retired_d;
    end
  end

  // R0 is never written, so it always reads as zero.
  assign RegWr   = valid_q && wr_q && (rd_q != AW'(REG_ZERO));
  assign Rd      = rd_q;
  assign WBbus   = wbbus_q;
  assign retired = retired_q;

  wb_fwd_cmp #(.AW(AW)) u_fwd_cmp (
    .wr_en   (RegWr),
    .wr_addr (rd_q),
    .rs1     (Rs1),
    .rs2     (Rs2),
    .fwd_a   (FwdA),
    .fwd_b   (FwdB)
  );

endmodule

// File: tb/tb_wb_stage_writer.sv
// Self-checking bench for wb_stage_writer: directed vector table, register
// file observation, randomized run against a reference model, counter wrap.
module tb_wb_stage_writer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_RegWr, stall, flush;
  logic [2:0]  in_Rd, Rs1, Rs2;
  logic [1:0]  in_WBsel;
  logic [15:0] in_ALUres, in_MemData, in_PCplus, in_Imm;
  logic        RegWr, FwdA, FwdB;
  logic [2:0]  Rd;
  logic [15:0] WBbus, retired;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] rf [8];

  always #5 clk = ~clk;

  wb_stage_writer dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_RegWr(in_RegWr),
    .in_Rd(in_Rd), .in_WBsel(in_WBsel), .in_ALUres(in_ALUres),
    .in_MemData(in_MemData), .in_PCplus(in_PCplus), .in_Imm(in_Imm),
    .stall(stall), .flush(flush), .Rs1(Rs1), .Rs2(Rs2),
    .RegWr(RegWr), .Rd(Rd), .WBbus(WBbus), .FwdA(FwdA), .FwdB(FwdB),
    .retired(retired)
  );

  // Plain register file driven by the stage, with no R0 masking of its own.
  always @(posedge clk) if (RegWr) rf[Rd] <= WBbus;

  typedef struct {
    logic        rst_n, valid, wr, stall, flush;
    logic [2:0]  rd, rs1, rs2;
    logic [1:0]  sel;
    logic [15:0] alu, mem, pc, imm;
    logic        e_wr, e_fa, e_fb;
    logic [2:0]  e_rd;
    logic [15:0] e_wb, e_ret;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic v, input logic w, input logic [2:0] d,
                       input logic [1:0] s, input logic [15:0] a, input logic [15:0] m,
                       input logic [15:0] p, input logic [15:0] i, input logic st,
                       input logic fl, input logic [2:0] r1, input logic [2:0] r2);
    rst_n = r; in_valid = v; in_RegWr = w; in_Rd = d; in_WBsel = s;
    in_ALUres = a; in_MemData = m; in_PCplus = p; in_Imm = i;
    stall = st; flush = fl; Rs1 = r1; Rs2 = r2;
  endtask

  task automatic add(input logic r, input logic v, input logic w, input logic [2:0] d,
                     input logic [1:0] s, input logic [15:0] data, input logic st,
                     input logic fl, input logic [2:0] r1, input logic [2:0] r2,
                     input logic ew, input logic [2:0] erd, input logic [15:0] ewb,
                     input logic efa, input logic efb, input logic [15:0] eret);
    vec_t t;
    t.rst_n = r; t.valid = v; t.wr = w; t.rd = d; t.sel = s; t.stall = st; t.flush = fl;
    t.rs1 = r1; t.rs2 = r2;
    // Only the selected source carries the data; the others carry decoys.
    t.alu = (s == 2'd0) ? data : 16'h0A0A;
    t.mem = (s == 2'd1) ? data : 16'h0B0B;
    t.pc  = (s == 2'd2) ? data : 16'h0C0C;
    t.imm = (s == 2'd3) ? data : 16'h0D0D;
    t.e_wr = ew; t.e_rd = erd; t.e_wb = ewb; t.e_fa = efa; t.e_fb = efb; t.e_ret = eret;
    vecs.push_back(t);
  endtask

  // Reference model state: the pending write and the instruction count.
  logic        m_en;
  logic [2:0]  m_rd;
  logic [15:0] m_data, m_cnt;

  task automatic model_step();
    logic [15:0] src [4];
    src[0] = in_ALUres; src[1] = in_MemData; src[2] = in_PCplus; src[3] = in_Imm;
    if (!rst_n) begin
      m_en = 0; m_rd = 0; m_data = 0; m_cnt = 0;
    end else if (flush || stall) begin
      m_en = 0;
    end else begin
      m_rd   = in_Rd;
      m_data = src[in_WBsel];
      m_en   = in_valid && in_RegWr && (in_Rd != 0);
      m_cnt  = m_cnt + (in_valid ? 16'd1 : 16'd0);
    end
  endtask

  task automatic compare_model(input string tag);
    check({tag, ".RegWr"},   RegWr,   m_en);
    check({tag, ".Rd"},      Rd,      m_rd);
    check({tag, ".WBbus"},   WBbus,   m_data);
    check({tag, ".FwdA"},    FwdA,    m_en && (Rs1 == m_rd));
    check({tag, ".FwdB"},    FwdB,    m_en && (Rs2 == m_rd));
    check({tag, ".retired"}, retired, m_cnt);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) rf[i] = 16'h0000;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();

    //  rst v  w  rd sel data      st fl rs1 rs2 | eWr eRd eWB       fa fb ret
    add(0, 1, 1, 5, 0, 16'h5A5A, 0, 0, 5, 5,    0, 0, 16'h0000, 0, 0, 16'd0);
    add(1, 1, 1, 3, 0, 16'hCCCC, 0, 0, 3, 1,    1, 3, 16'hCCCC, 1, 0, 16'd1);
    add(1, 0, 1, 6, 0, 16'h1234, 0, 0, 6, 6,    0, 6, 16'h1234, 0, 0, 16'd1);
    add(1, 1, 1, 1, 1, 16'hAAAA, 0, 0, 2, 1,    1, 1, 16'hAAAA, 0, 1, 16'd2);
    add(1, 1, 1, 2, 2, 16'h0011, 0, 0, 2, 0,    1, 2, 16'h0011, 1, 0, 16'd3);
    add(1, 1, 1, 7, 3, 16'hEEEE, 0, 0, 7, 7,    1, 7, 16'hEEEE, 1, 1, 16'd4);
    add(1, 1, 1, 0, 0, 16'hFFFF, 0, 0, 0, 0,    0, 0, 16'hFFFF, 0, 0, 16'd5);
    add(1, 1, 1, 5, 0, 16'h5555, 1, 0, 0, 5,    0, 0, 16'hFFFF, 0, 0, 16'd5);
    add(1, 1, 1, 5, 0, 16'h5555, 0, 1, 0, 5,    0, 0, 16'hFFFF, 0, 0, 16'd5);
    add(1, 1, 1, 5, 0, 16'h5555, 1, 1, 0, 5,    0, 0, 16'hFFFF, 0, 0, 16'd5);
    add(1, 1, 1, 4, 0, 16'h4444, 0, 0, 4, 4,    1, 4, 16'h4444, 1, 1, 16'd6);
    add(1, 1, 1, 4, 1, 16'h4545, 0, 0, 5, 4,    1, 4, 16'h4545, 0, 1, 16'd7);
    add(1, 1, 0, 3, 0, 16'h3333, 0, 0, 3, 3,    0, 3, 16'h3333, 0, 0, 16'd8);
    add(0, 1, 1, 2, 0, 16'h2222, 0, 0, 0, 0,    0, 0, 16'h0000, 0, 0, 16'd0);

    foreach (vecs[k]) begin
      drive(vecs[k].rst_n, vecs[k].valid, vecs[k].wr, vecs[k].rd, vecs[k].sel,
            vecs[k].alu, vecs[k].mem, vecs[k].pc, vecs[k].imm,
            vecs[k].stall, vecs[k].flush, vecs[k].rs1, vecs[k].rs2);
      tick();
      check($sformatf("vec%0d.RegWr", k),   RegWr,   vecs[k].e_wr);
      check($sformatf("vec%0d.Rd", k),      Rd,      vecs[k].e_rd);
      check($sformatf("vec%0d.WBbus", k),   WBbus,   vecs[k].e_wb);
      check($sformatf("vec%0d.FwdA", k),    FwdA,    vecs[k].e_fa);
      check($sformatf("vec%0d.FwdB", k),    FwdB,    vecs[k].e_fb);
      check($sformatf("vec%0d.retired", k), retired, vecs[k].e_ret);
    end

    // Writes committed by the stream above, and R0 untouched.
    check("rf.R3", rf[3], 16'hCCCC);
    check("rf.R1", rf[1], 16'hAAAA);
    check("rf.R2", rf[2], 16'h0011);
    check("rf.R7", rf[7], 16'hEEEE);
    check("rf.R4", rf[4], 16'h4545);
    check("rf.R0", rf[0], 16'h0000);
    check("rf.R5", rf[5], 16'h0000);

    // Reset held low: still nothing captured, and flags clear.
    tick();
    check("rst_hold.RegWr", RegWr, 1'b0);
    check("rst_hold.retired", retired, 16'd0);
    check("rst_hold.FwdA", FwdA, 1'b0);

    // Duplicate-write guard: one RegWr pulse, gone once the input is a bubble.
    drive(1, 1, 1, 6, 3, 0, 0, 0, 16'h6666, 0, 0, 6, 0);
    tick();
    check("pulse.on", RegWr, 1'b1);
    drive(1, 1, 1, 6, 3, 0, 0, 0, 16'h6666, 1, 0, 6, 0);
    tick();
    check("pulse.off_stall", RegWr, 1'b0);
    check("pulse.hold_wb", WBbus, 16'h6666);
    check("rf.R6", rf[6], 16'h6666);

    // Randomized run against the reference model.
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    model_step();
    for (int c = 0; c < 2000; c++) begin
      drive(($urandom_range(63) != 0), ($urandom_range(3) != 0), $urandom_range(1),
            3'($urandom_range(7)), 2'($urandom_range(3)),
            16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
            ($urandom_range(7) == 0), ($urandom_range(7) == 0),
            3'($urandom_range(7)), 3'($urandom_range(7)));
      tick();
      model_step();
      compare_model($sformatf("rnd%0d", c));
    end

    // Counter wrap: 65535 valid instructions, then one more.
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    drive(1, 1, 0, 1, 0, 16'h0001, 0, 0, 0, 0, 0, 2, 3);
    for (int c = 0; c < 65535; c++) tick();
    check("wrap.max", retired, 16'hFFFF);
    tick();
    check("wrap.zero", retired, 16'h0000);
    check("wrap.no_write", RegWr, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
